// File: rtl/prince_sbox_cms_layer.sv
// prince_sbox_cms_layer
// First-order CMS-masked PRINCE S-box layer: NIBBLES parallel 4-bit S-boxes,
// two input shares in, two output shares out, two register stages
// (expansion/refresh, then compression) behind a valid/ready stream interface.
// Optional feature macro: PRINCE_SBOX_INV_EN adds an 'inv' input that selects
// the inverse S-box per beat.
module prince_sbox_cms_layer #(
    parameter int NIBBLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_sh0,
    input  logic [4*NIBBLES-1:0]   in_sh1,
    input  logic [28*NIBBLES-1:0]  rand_in,
`ifdef PRINCE_SBOX_INV_EN
    input  logic                   inv,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sh0,
    output logic [4*NIBBLES-1:0]   out_sh1
);

    localparam int NB  = 4 * NIBBLES;
    localparam int NSH = 8 * NB;

    // Truth tables, nibble x holds S(x)
    localparam logic [63:0] SBOX_FWD = 64'h4D5E_0876_19CA_23FB;
`ifdef PRINCE_SBOX_INV_EN
    localparam logic [63:0] SBOX_INV = 64'h1CE5_046A_98DF_237B;
`endif

    // Algebraic normal form of output bit j (Moebius transform of its truth table)
    function automatic logic [15:0] anf_of(input logic [63:0] tbl, input int j);
        logic [15:0] a;
        for (int x = 0; x < 16; x++) a[x] = tbl[4*x+j];
        for (int i = 0; i < 4; i++)
            for (int x = 0; x < 16; x++)
                if ((x & (1 << i)) != 0) a[x] = a[x] ^ a[x ^ (1 << i)];
        return a;
    endfunction

    // One CMS share t = {a,b,c} of a cubic function given by its ANF.
    // x0, x1, x2 sit on index positions a, b, c; x3 takes the first position
    // left free by the other variables of the monomial. A monomial lands in
    // share t only if t is zero on every position the monomial leaves unused,
    // so summing all 8 shares rebuilds each monomial exactly once.
    function automatic logic cms_share(input logic [15:0] anf, input logic [3:0] s0,
                                       input logic [3:0] s1, input logic [2:0] t);
        logic       acc;
        logic       prod;
        logic       found;
        logic [2:0] used;
        logic [3:0] m;
        int         p3;
        acc = 1'b0;
        for (int mi = 0; mi < 16; mi++) begin
            m     = 4'(mi);
            used  = {m[0], m[1], m[2]};
            p3    = 0;
            found = 1'b0;
            if (m[3]) begin
                for (int p = 2; p >= 0; p--) begin
                    if (!used[p] && !found) begin
                        p3    = p;
                        found = 1'b1;
                    end
                end
                if (found) used[p3] = 1'b1;
            end
            prod = 1'b1;
            for (int v = 0; v < 3; v++)
                if (m[v]) prod = prod & (t[2-v] ? s1[v] : s0[v]);
            if (m[3] && found) prod = prod & (t[p3] ? s1[3] : s0[3]);
            if (anf[mi] && ((t & ~used) == 3'b000) && !(m[3] && !found))
                acc = acc ^ prod;
        end
        return acc;
    endfunction

    logic [NSH-1:0] share_next;
    logic [NSH-1:0] share_reg;
    logic [NB-1:0]  comp0_next;
    logic [NB-1:0]  comp1_next;
    logic [NB-1:0]  out0_reg;
    logic [NB-1:0]  out1_reg;
    logic           v1_reg;
    logic           v2_reg;
    logic           adv1;
    logic           adv2;

    assign adv2      = !v2_reg || out_ready;
    assign adv1      = adv2 || !v1_reg;
    assign in_ready  = adv1;
    assign out_valid = v2_reg;
    assign out_sh0   = out0_reg;
    assign out_sh1   = out1_reg;

    genvar gi, gj, gk;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            for (gj = 0; gj < 4; gj++) begin : g_bit
                localparam logic [15:0] ANF_F = anf_of(SBOX_FWD, gj);
`ifdef PRINCE_SBOX_INV_EN
                localparam logic [15:0] ANF_I = anf_of(SBOX_INV, gj);
`endif
                localparam int BASE = (gi*4 + gj) * 8;
                localparam int RB   = gi*28 + gj*7;
                for (gk = 0; gk < 8; gk++) begin : g_sh
                    logic mask_bit;
                    logic raw_bit;
                    // Last mask closes the sum of masks to zero
                    if (gk < 7) begin : g_fresh
                        assign mask_bit = rand_in[RB + gk];
                    end else begin : g_close
                        assign mask_bit = ^rand_in[RB +: 7];
                    end
`ifdef PRINCE_SBOX_INV_EN
                    assign raw_bit = inv ? cms_share(ANF_I, in_sh0[4*gi +: 4], in_sh1[4*gi +: 4], 3'(gk))
                                         : cms_share(ANF_F, in_sh0[4*gi +: 4], in_sh1[4*gi +: 4], 3'(gk));
`else
                    assign raw_bit = cms_share(ANF_F, in_sh0[4*gi +: 4], in_sh1[4*gi +: 4], 3'(gk));
`endif
                    assign share_next[BASE + gk] = raw_bit ^ mask_bit;
                end
                // Compression reads registered shares only: a=0 half and a=1 half
                assign comp0_next[gi*4 + gj] = ^share_reg[BASE +: 4];
                assign comp1_next[gi*4 + gj] = ^share_reg[BASE + 4 +: 4];
            end
        end
    endgenerate

    // Stage 1: capture masked expanded shares of an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg    <= 1'b0;
            share_reg <= '0;
        end else if (adv1) begin
            v1_reg <= in_valid;
            if (in_valid) share_reg <= share_next;
        end
    end

    // Stage 2: compress into the output share registers when the slot frees up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_reg   <= 1'b0;
            out0_reg <= '0;
            out1_reg <= '0;
        end else if (adv2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                out0_reg <= comp0_next;
                out1_reg <= comp1_next;
            end
        end
    end

endmodule

// File: tb/tb_prince_sbox_cms_layer.sv
// Testbench for prince_sbox_cms_layer: random shares and masks, S-box lookup
// reference model with an expected-beat queue, directed handshake scenarios.
module tb_prince_sbox_cms_layer;

    localparam int N = 16;

    localparam logic [3:0] SFWD [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                         4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
    localparam logic [3:0] SINV [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                         4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_sh0 = '0;
    logic [63:0]   in_sh1 = '0;
    logic [447:0]  rand_in = '0;
    logic          inv = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   out_sh0;
    logic [63:0]   out_sh1;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [63:0] sh0_q[$];
    bit          last_acc;
    bit          hold;
    logic [63:0] snap0, snap1;

    prince_sbox_cms_layer #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh0    (in_sh0),
        .in_sh1    (in_sh1),
        .rand_in   (rand_in),
`ifdef PRINCE_SBOX_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh0   (out_sh0),
        .out_sh1   (out_sh1)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_sbox(input logic [63:0] x, input logic inv_sel);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < N; n++)
            y[4*n +: 4] = inv_sel ? SINV[x[4*n +: 4]] : SFWD[x[4*n +: 4]];
        return y;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // New random sharing of x plus fresh masks
    task automatic set_beat(input logic [63:0] x);
        in_sh0 = {$urandom, $urandom};
        in_sh1 = in_sh0 ^ x;
        for (int w = 0; w < 14; w++) rand_in[w*32 +: 32] = $urandom;
    endtask

    // One clock cycle: inputs already driven; observe handshakes, then step
    task automatic cycle();
        logic [63:0] e;
        #1;
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            check("beat_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sbox_out", out_sh0 ^ out_sh1, e);
            end
            got_q.push_back(out_sh0 ^ out_sh1);
            sh0_q.push_back(out_sh0);
        end
        if (last_acc) exp_q.push_back(ref_sbox(in_sh0 ^ in_sh1, inv));
        hold  = out_valid && !out_ready;
        snap0 = out_sh0;
        snap1 = out_sh1;
        @(posedge clk);
        #1;
        if (hold) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_sh0", out_sh0, snap0);
            check("hold_sh1", out_sh1, snap1);
        end
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        logic [63:0] x;
        logic [63:0] bp [5];
        logic [63:0] orig [16];
        logic [63:0] mid [16];
        int idx;
        int distinct;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sh0", out_sh0, 64'd0);
        check("rst_out_sh1", out_sh1, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Every nibble position sees every input value, back to back
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int n = 0; n < N; n++) x[4*n +: 4] = 4'((n + k) % 16);
            set_beat(x);
            in_valid = 1'b1;
            cycle();
            check("stream_accept", 64'(last_acc), 64'd1);
        end
        drain(4);
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Latency of a single beat
        set_beat({$urandom, $urandom});
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("lat_t1", 64'(out_valid), 64'd0);
        cycle();
        check("lat_t2", 64'(out_valid), 64'd1);
        cycle();
        check("lat_t3", 64'(out_valid), 64'd0);

        // Back-pressure: five beats against a stalled sink
        for (int i = 0; i < 5; i++) bp[i] = {$urandom, $urandom};
        got_q.delete();
        out_ready = 1'b0;
        idx = 0;
        set_beat(bp[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (last_acc) begin
                idx++;
                if (idx < 5) set_beat(bp[idx]);
            end
        end
        check("bp_accepted", 64'(idx), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && !(idx == 5 && exp_q.size() == 0); c++) begin
            in_valid = (idx < 5);
            cycle();
            if (last_acc) begin
                idx++;
                if (idx < 5) set_beat(bp[idx]);
            end
        end
        check("bp_all_accepted", 64'(idx), 64'd5);
        check("bp_emitted", 64'(got_q.size()), 64'd5);
        for (int i = 0; i < got_q.size() && i < 5; i++)
            check("bp_order", got_q[i], ref_sbox(bp[i], 1'b0));

        // Reset with both stages occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_beat({$urandom, $urandom});
        cycle();
        set_beat({$urandom, $urandom});
        cycle();
        check("mid_full_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        got_q.delete();
        hold = 1'b0;
        #1;
        rst_n = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(5);
        check("mid_no_stale", 64'(got_q.size()), 64'd0);

        // Mask independence on x = 3 everywhere
        sh0_q.delete();
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            set_beat(64'h3333_3333_3333_3333);
            in_valid = 1'b1;
            cycle();
        end
        drain(4);
        check("mask_count", 64'(got_q.size()), 64'd6);
        for (int i = 0; i < got_q.size(); i++)
            check("mask_xor", got_q[i], 64'h2222_2222_2222_2222);
        distinct = 0;
        for (int i = 1; i < sh0_q.size(); i++)
            if (sh0_q[i] !== sh0_q[0]) distinct++;
        check("mask_sh0_varies", 64'(distinct != 0), 64'd1);

`ifdef PRINCE_SBOX_INV_EN
        // Alternating direction on x = 6
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            inv = (i % 2) == 1;
            set_beat(64'h6666_6666_6666_6666);
            in_valid = 1'b1;
            cycle();
        end
        inv = 1'b0;
        drain(4);
        check("inv_alt_count", 64'(got_q.size()), 64'd4);
        if (got_q.size() >= 2) begin
            check("inv_alt_fwd", got_q[0], 64'h9999_9999_9999_9999);
            check("inv_alt_inv", got_q[1], 64'h8888_8888_8888_8888);
        end

        // Round trip: forward pass then inverse pass returns the input
        got_q.delete();
        for (int k = 0; k < 16; k++) begin
            for (int n = 0; n < N; n++) orig[k][4*n +: 4] = 4'((n + k) % 16);
            set_beat(orig[k]);
            in_valid = 1'b1;
            cycle();
        end
        drain(4);
        for (int k = 0; k < 16; k++) mid[k] = (k < got_q.size()) ? got_q[k] : 64'd0;
        got_q.delete();
        inv = 1'b1;
        for (int k = 0; k < 16; k++) begin
            set_beat(mid[k]);
            in_valid = 1'b1;
            cycle();
        end
        drain(4);
        inv = 1'b0;
        check("rt_count", 64'(got_q.size()), 64'd16);
        for (int k = 0; k < got_q.size() && k < 16; k++)
            check("rt_value", got_q[k], orig[k]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
